ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Execute-stage iterative multiply/divide unit.
- Consumes operands and the decoded mul/div op held in the ID/EX pipeline register outputs.
- Owns the architectural HI/LO registers: runs MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO writes.
- Raises a stall request to the hazard logic when a later instruction needs HI/LO or the unit while it is busy.

Parameters:
- XLEN, 32, operand/HI/LO width.
- ITERS, 32, iteration cycles per operation; equals XLEN.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of an in-flight operation; same pulse that clears ID/EX.
- start  in  1  EX-stage instruction is a mul/div; sampled when idle.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  XLEN  rs operand (post-forwarding).
- src_b  in  XLEN  rt operand (post-forwarding).
- mthi  in  1  write src_a to HI.
- mtlo  in  1  write src_a to LO.
- read_hilo  in  1  EX-stage instruction is MFHI/MFLO.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- stall  out  1  combinational; equals busy & (start | read_hilo | mthi | mtlo).

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; hi, lo, busy, done and all internal accumulators = 0.
  - Reset mid-operation discards the operation immediately.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 latches op and operands, goes to RUN; busy=1 after E0.
  - Signed ops latch magnitudes |a|, |b| and the sign flags.
- RUN:
  - One iteration per edge, E1..E32, with a 6-bit iteration counter; moves to FIX after the 32nd iteration.
  - Multiply: shift-add on a 2*XLEN accumulator; multiplier LSB selects add of the multiplicand into the upper half, then shift right 1.
  - Divide: restoring. Shift the {rem,quot} 2*XLEN register left 1; trial-subtract the divisor from the upper half; if non-negative, keep the result and set quot LSB.
- FIX (edge E33):
  - Applies signs and writes HI/LO; state goes to IDLE, busy goes to 0, done=1 for exactly the cycle after E33.
  - HI/LO therefore hold the new value 33 edges after the start edge.
  - MULT: product negated (64-bit two's complement) if sign_a^sign_b.
  - DIV: quotient negated if sign_a^sign_b; remainder takes sign_a.
  - Overflow case 0x80000000 / -1 gives LO=0x80000000, HI=0; no trap.
- Divide by zero (src_b=0, either DIV op): HI=src_a as latched (signed ops keep the original src_a value), LO=0xFFFFFFFF, same 33-cycle latency.
- MTHI/MTLO in IDLE: write at the next edge. Both asserted in the same cycle write both.
- start and mthi/mtlo in the same cycle: start wins; the writes are ignored.
- start, mthi or mtlo while busy: ignored. The stall output must hold the pipeline, so the instruction re-presents after done.
- flush:
  - In RUN or FIX: return to IDLE at the next edge; HI/LO unchanged; no done pulse.
  - In IDLE: blocks start, mthi and mtlo that cycle.
  - flush outranks everything except rst_n.
- done is never asserted while busy=1.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: multiply leaves RUN as soon as the remaining shifted multiplier is zero (minimum 1 RUN cycle). The accumulator is aligned by the remaining shift count in FIX. MULTU x*1 completes with done at start+3 edges. Divide is unaffected.
- Undefined: every operation takes exactly 32 RUN cycles (fixed 33-edge latency).

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encodings S_IDLE/S_RUN/S_FIX;
  - XLEN and ITERS constants.
- One sub-module, muldiv_step: combinational single iteration (shift-add or restoring subtract). Inputs: accumulator and operand; outputs: next accumulator. The FSM/sign logic stays in ex_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF: start at E0 → busy E0+..E33, HI=0xFFFFFFFE, LO=0x00000001 after E33, done 1 cycle.
- MULT -3*7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100/7 → LO=14, HI=2.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 0x12345678/0 → HI=0x12345678, LO=0xFFFFFFFF after 33 edges; no X on outputs.
- Abort cases:
  - Preload HI=0xA, LO=0xB via mthi/mtlo in IDLE; start DIVU; flush at RUN iteration 10 → busy=0 next cycle, HI=0xA, LO=0xB, done never pulses.
  - Repeat with rst_n low mid-RUN → hi=lo=0 immediately, without waiting for a clock.
- Hold checks:
  - read_hilo=1 during RUN → stall=1 every cycle until busy falls, then 0.
  - start asserted while busy → ignored; second op runs only after re-presentation, result matches the second operands.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, encodings and helpers for the execute-stage
// multiply/divide unit (ex_muldiv) and its iteration datapath (muldiv_step).
//   XLEN   operand / HI / LO width
//   ITERS  iteration cycles per operation (equals XLEN)
//   CNT_W  width of the iteration counter
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Magnitude of a two's complement value when is_signed is set; the most
  // negative value maps onto itself, which is correct read as unsigned.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                               input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: pipeline-side bundle of the multiply/divide unit.
//   master (ID/EX pipeline + hazard logic):
//     drives flush, start, op, src_a, src_b, mthi, mtlo, read_hilo
//     observes hi, lo, busy, done, stall, dbg_state
//   slave (ex_muldiv): the reverse directions.
//
// Handshake: start/mthi/mtlo/read_hilo are level requests from the EX-stage
// instruction. A request is consumed only at an edge where stall is 0;
// while stall is 1 the pipeline must hold the instruction and keep the
// request asserted, so it re-presents once busy falls. done pulses for one
// cycle when an operation has just written HI/LO; it is never high with busy.
interface ex_muldiv_if;
  import muldiv_pkg::*;

  logic            flush;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            mthi;
  logic            mtlo;
  logic            read_hilo;

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            stall;
  state_e          dbg_state;

  modport master (
    output flush, start, op, src_a, src_b, mthi, mtlo, read_hilo,
    input  hi, lo, busy, done, stall, dbg_state
  );

  modport slave (
    input  flush, start, op, src_a, src_b, mthi, mtlo, read_hilo,
    output hi, lo, busy, done, stall, dbg_state
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div_i  1: restoring-divide step, 0: shift-add multiply step
//   acc_i     2*XLEN accumulator ({upper, lower})
//   opnd_i    multiplicand (multiply) or divisor (divide) magnitude
//   acc_o     accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] trial;
  logic            fits;

  always_comb begin
    // Multiply: multiplier LSB selects adding the multiplicand into the upper
    // half; the carry is kept and shifted back in from the top.
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: upper half after the left shift needs XLEN+1 bits. Remainder
    // stays below the divisor, so the subtracted result fits in XLEN bits.
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    fits   = (rem_sh >= {1'b0, opnd_i});
    trial  = acc_i[2*XLEN-2:XLEN-1] - opnd_i;

    if (is_div_i) begin
      if (fits) begin
        acc_o = {trial, acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage iterative multiply/divide unit owning HI/LO.
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ex_muldiv_if.slave: flush, start, op, src_a, src_b, mthi, mtlo,
//          read_hilo in; hi, lo, busy, done, stall, dbg_state out
// Operations: MULT/MULTU/DIV/DIVU over ITERS RUN cycles plus one FIX cycle
// (HI/LO valid 33 edges after the start edge); MTHI/MTLO write in IDLE.
// Build option MULDIV_EARLY_TERM_EN: multiplies leave RUN once the remaining
// multiplier is zero; without it every operation has the fixed latency.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ex_muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_al;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic              is_div, op_signed, in_signed, busy, mul_early_exit;

  assign is_div    = op_q[1];
  assign op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign in_signed = ~bus.op[0];
  assign busy      = (state_q != S_IDLE);

`ifdef MULDIV_EARLY_TERM_EN
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ITERS);
  logic [XLEN-1:0] mplier_q, mplier_d;

  // Checked before stepping, so at least one RUN iteration always happens.
  assign mul_early_exit = !is_div && (cnt_q != '0) && (mplier_q == '0);
  // After k iterations the product sits in the top XLEN+k bits.
  assign prod_al        = acc_q >> (FULL_CNT - cnt_q);
`else
  assign mul_early_exit = 1'b0;
  assign prod_al        = acc_q;
`endif

  muldiv_step u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // Sign fix-up applied in FIX.
  always_comb begin
    prod = (op_signed && (sign_a_q ^ sign_b_q)) ? -prod_al : prod_al;
    quot = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (op_signed && (sign_a_q ^ sign_b_q)) quot = -quot;
    if (op_signed && sign_a_q)              rem  = -rem;

    if (!is_div) begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end else if (div0_q) begin
      // HI returns the dividend exactly as presented, not its magnitude.
      res_hi = a_raw_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
    mplier_d = mplier_q;
`endif

    case (state_q)
      S_IDLE: begin
        // flush kills the EX instruction, so none of its requests take effect.
        if (!bus.flush) begin
          if (bus.start) begin
            op_d     = bus.op;
            sign_a_d = in_signed & bus.src_a[XLEN-1];
            sign_b_d = in_signed & bus.src_b[XLEN-1];
            a_raw_d  = bus.src_a;
            div0_d   = (bus.src_b == '0);
            cnt_d    = '0;
            state_d  = S_RUN;
            if (bus.op[1]) begin
              acc_d  = {{XLEN{1'b0}}, abs_val(bus.src_a, in_signed)};
              opnd_d = abs_val(bus.src_b, in_signed);
            end else begin
              acc_d  = {{XLEN{1'b0}}, abs_val(bus.src_b, in_signed)};
              opnd_d = abs_val(bus.src_a, in_signed);
            end
`ifdef MULDIV_EARLY_TERM_EN
            mplier_d = abs_val(bus.src_b, in_signed);
`endif
          end else begin
            if (bus.mthi) hi_d = bus.src_a;
            if (bus.mtlo) lo_d = bus.src_a;
          end
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (mul_early_exit) begin
          state_d = S_FIX;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
          mplier_d = mplier_q >> 1;
`endif
          if (cnt_q == LAST_ITER) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef MULDIV_EARLY_TERM_EN
      mplier_q <= mplier_d;
`endif
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.stall     = busy & (bus.start | bus.read_hilo | bus.mthi | bus.mtlo);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (default build).
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.read_hilo = 1'b0;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    bus.mthi = 1'b1; bus.src_a = h; tick(); bus.mthi = 1'b0;
    bus.mtlo = 1'b1; bus.src_a = l; tick(); bus.mtlo = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    n_cmp++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b done=%b stall=%b expected 0 0 0", bus.busy, bus.done, bus.stall);
    end
    n_cmp++; if (bus.dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, S_IDLE); end
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_mthi_mtlo();
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.src_a = 32'h55; tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    n_cmp++; if (bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
      n_fail++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 55 55", bus.hi, bus.lo);
    end
    bus.mthi = 1'b1; bus.src_a = 32'hA; tick(); bus.mthi = 1'b0;
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'h55) begin
      n_fail++; $display("FAIL mthi_only: got hi=%h lo=%h expected a 55", bus.hi, bus.lo);
    end
    bus.mtlo = 1'b1; bus.src_a = 32'hB; tick(); bus.mtlo = 1'b0;
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB) begin
      n_fail++; $display("FAIL mtlo_only: got hi=%h lo=%h expected a b", bus.hi, bus.lo);
    end
  endtask

  // Directed arithmetic vectors with hand-computed HI/LO.
  logic [1:0]  v_op [11];
  logic [31:0] v_a  [11];
  logic [31:0] v_b  [11];
  logic [31:0] v_hi [11];
  logic [31:0] v_lo [11];
  string       v_nm [11];

  task automatic test_arith();
    logic bad;
    v_op[0]  = OP_MULTU; v_a[0]  = 32'hFFFFFFFF; v_b[0]  = 32'hFFFFFFFF; v_hi[0]  = 32'hFFFFFFFE; v_lo[0]  = 32'h00000001; v_nm[0]  = "multu_max";
    v_op[1]  = OP_MULT;  v_a[1]  = 32'hFFFFFFFD; v_b[1]  = 32'd7;        v_hi[1]  = 32'hFFFFFFFF; v_lo[1]  = 32'hFFFFFFEB; v_nm[1]  = "mult_neg3x7";
    v_op[2]  = OP_DIVU;  v_a[2]  = 32'd100;      v_b[2]  = 32'd7;        v_hi[2]  = 32'd2;        v_lo[2]  = 32'd14;       v_nm[2]  = "divu_100_7";
    v_op[3]  = OP_DIV;   v_a[3]  = 32'hFFFFFFF9; v_b[3]  = 32'd2;        v_hi[3]  = 32'hFFFFFFFF; v_lo[3]  = 32'hFFFFFFFD; v_nm[3]  = "div_neg7_2";
    v_op[4]  = OP_DIV;   v_a[4]  = 32'h80000000; v_b[4]  = 32'hFFFFFFFF; v_hi[4]  = 32'h0;        v_lo[4]  = 32'h80000000; v_nm[4]  = "div_overflow";
    v_op[5]  = OP_DIV;   v_a[5]  = 32'h12345678; v_b[5]  = 32'h0;        v_hi[5]  = 32'h12345678; v_lo[5]  = 32'hFFFFFFFF; v_nm[5]  = "div_by_zero";
    v_op[6]  = OP_DIV;   v_a[6]  = 32'hFFFFFFF9; v_b[6]  = 32'h0;        v_hi[6]  = 32'hFFFFFFF9; v_lo[6]  = 32'hFFFFFFFF; v_nm[6]  = "div_neg_by_zero";
    v_op[7]  = OP_MULTU; v_a[7]  = 32'h12345678; v_b[7]  = 32'h10;       v_hi[7]  = 32'h00000001; v_lo[7]  = 32'h23456780; v_nm[7]  = "multu_shift";
    v_op[8]  = OP_DIVU;  v_a[8]  = 32'hFFFFFFFF; v_b[8]  = 32'd1;        v_hi[8]  = 32'h0;        v_lo[8]  = 32'hFFFFFFFF; v_nm[8]  = "divu_max_1";
    v_op[9]  = OP_MULT;  v_a[9]  = 32'h80000000; v_b[9]  = 32'h80000000; v_hi[9]  = 32'h40000000; v_lo[9]  = 32'h0;        v_nm[9]  = "mult_minxmin";
    v_op[10] = OP_DIV;   v_a[10] = 32'd7;        v_b[10] = 32'hFFFFFFFE; v_hi[10] = 32'd1;        v_lo[10] = 32'hFFFFFFFD; v_nm[10] = "div_7_neg2";

    for (int i = 0; i < 11; i++) begin
      bus.start = 1'b1; bus.op = v_op[i]; bus.src_a = v_a[i]; bus.src_b = v_b[i];
      tick();  // E0
      bus.start = 1'b0;
      bus.src_a = $urandom; bus.src_b = $urandom;  // operands must already be latched
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_e0: got %b expected 1", v_nm[i], bus.busy); end
      bad = 1'b0;
      for (int e = 1; e < 33; e++) begin
        tick();
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_fail++; $display("FAIL %s_busy_run: got early completion expected busy through E32", v_nm[i]); end
      tick();  // E33
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL %s_done_e33: got done=%b busy=%b expected 1 0", v_nm[i], bus.done, bus.busy);
      end
      n_cmp++; if (bus.hi !== v_hi[i]) begin n_fail++; $display("FAIL %s_hi: got %h expected %h", v_nm[i], bus.hi, v_hi[i]); end
      n_cmp++; if (bus.lo !== v_lo[i]) begin n_fail++; $display("FAIL %s_lo: got %h expected %h", v_nm[i], bus.lo, v_lo[i]); end
      tick();
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b expected 0", v_nm[i], bus.done); end
    end
  endtask

  task automatic test_start_wins();
    write_hilo(32'hA, 32'hB);
    bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
    tick();
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL start_wins_e0: got hi=%h lo=%h busy=%b expected a b 1", bus.hi, bus.lo, bus.busy);
    end
    for (int e = 1; e <= 33; e++) tick();
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'd15 || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL start_wins_result: got hi=%h lo=%h done=%b expected 0 f 1", bus.hi, bus.lo, bus.done);
    end
  endtask

  task automatic test_flush_idle();
    // hi=0, lo=15 from the previous test
    bus.flush = 1'b1; bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    bus.op = OP_DIVU; bus.src_a = 32'h77; bus.src_b = 32'd1;
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      n_fail++; $display("FAIL flush_idle: got busy=%b hi=%h lo=%h expected 0 0 f", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    logic saw_done;
    write_hilo(32'hA, 32'hB);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL flush_run_busy: got busy=%b state=%0d expected 0 %0d", bus.busy, bus.dbg_state, S_IDLE);
    end
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB) begin
      n_fail++; $display("FAIL flush_run_hilo: got hi=%h lo=%h expected a b", bus.hi, bus.lo);
    end
    saw_done = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_fail++; $display("FAIL flush_run_done: got done pulse expected none"); end

    // Flush landing exactly on the FIX cycle.
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e <= 32; e++) tick();
    n_cmp++; if (bus.dbg_state !== S_FIX) begin n_fail++; $display("FAIL flush_fix_state: got %0d expected %0d", bus.dbg_state, S_FIX); end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_fix: got hi=%h lo=%h done=%b busy=%b expected a b 0 0", bus.hi, bus.lo, bus.done, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    write_hilo(32'h11, 32'h22);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'hFFFFFFFF; bus.src_b = 32'hFFFFFFFF;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    #2;
    rst_n = 1'b0;
    #1;  // still well before the next rising edge
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_hilo: got hi=%h lo=%h expected 0 0", bus.hi, bus.lo);
    end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    #2;
    rst_n = 1'b1;
    for (int e = 0; e < 40; e++) tick();
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_discard: got hi=%h lo=%h busy=%b expected 0 0 0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_stall_read_hilo();
    logic bad;
    bus.read_hilo = 1'b1;
    bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %b expected 0", bus.stall); end
    tick();
    bus.start = 1'b0;
    bad = 1'b0;
    for (int e = 0; e < 32; e++) begin
      if (bus.stall !== 1'b1) bad = 1'b1;
      tick();
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL stall_run: got stall=0 during busy expected 1"); end
    tick();  // E33
    n_cmp++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got stall=%b busy=%b expected 0 0", bus.stall, bus.busy);
    end
    n_cmp++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      n_fail++; $display("FAIL stall_result: got hi=%h lo=%h expected 2 e", bus.hi, bus.lo);
    end
    bus.read_hilo = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd6; bus.src_b = 32'd7;
    tick();  // E0: first op accepted
    bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;  // second op held by stall
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b expected 1", bus.stall); end
    for (int e = 1; e <= 32; e++) tick();
    tick();  // E33
    n_cmp++; if (bus.done !== 1'b1 || bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
      n_fail++; $display("FAIL b2b_first: got done=%b hi=%h lo=%h expected 1 0 2a", bus.done, bus.hi, bus.lo);
    end
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_drop: got %b expected 0", bus.stall); end
    tick();  // E34: second op accepted on re-presentation
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.lo !== 32'd42) begin
      n_fail++; $display("FAIL b2b_second_start: got busy=%b done=%b lo=%h expected 1 0 2a", bus.busy, bus.done, bus.lo);
    end
    for (int e = 1; e <= 33; e++) tick();
    n_cmp++; if (bus.done !== 1'b1 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      n_fail++; $display("FAIL b2b_second: got done=%b hi=%h lo=%h expected 1 2 e", bus.done, bus.hi, bus.lo);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_mthi_mtlo();
    test_arith();
    test_start_wins();
    test_flush_idle();
    test_flush();
    test_async_reset();
    test_stall_read_hilo();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
